// File: rtl/ram_output_arbiter.sv
// ram_output_arbiter: round-robin write/read arbiter and hardware clear sequencer for the 16x8 output RAM.
// Build option: define ARB_FIXED_PRIO_EN for fixed write-over-read priority. Revision: 1.0
`default_nettype none

module ram_output_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr_start,
  output logic                  o_clr_busy,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_gnt,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_gnt,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_q
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_sweep_last = '1;
  localparam logic [ADDR_WIDTH-1:0] c_sweep_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic [ADDR_WIDTH-1:0] w_sweep_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_data;
  logic                  w_ram_we;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic                  w_clr_busy;
  logic                  w_wr_wins;
  logic                  r_rd_p1;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

`ifdef ARB_FIXED_PRIO_EN
  assign w_wr_wins = 1'b1;
`else
  // Set when the most recent grant went to the writer; reset favours the writer.
  logic r_last_wr;

  assign w_wr_wins = ~r_last_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_wr <= 1'b0;
    end else if (w_wr_gnt) begin
      r_last_wr <= 1'b1;
    end else if (w_rd_gnt) begin
      r_last_wr <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_wr_gnt    = 1'b0;
    w_rd_gnt    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_addr_hold;
    w_ram_data  = r_data_hold;
    w_clr_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst) begin
          if (i_wr_req && (!i_rd_req || w_wr_wins)) begin
            w_wr_gnt = 1'b1;
          end else if (i_rd_req) begin
            w_rd_gnt = 1'b1;
          end
        end
        if (w_wr_gnt) begin
          w_ram_we   = 1'b1;
          w_ram_addr = i_wr_addr;
          w_ram_data = i_wr_data;
        end else if (w_rd_gnt) begin
          w_ram_addr = i_rd_addr;
        end
        if (i_clr_start) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clr_busy  = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_addr  = r_sweep;
        w_ram_data  = '0;
        w_sweep_nxt = r_sweep + c_sweep_one;
        if (r_sweep == c_sweep_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sweep     <= '0;
      r_addr_hold <= '0;
      r_data_hold <= '0;
      r_rd_p1     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep     <= w_sweep_nxt;
      r_addr_hold <= w_ram_addr;
      r_data_hold <= w_ram_data;
      r_rd_p1     <= w_rd_gnt;
      r_rd_valid  <= r_rd_p1;
      // RAM output is valid the cycle after the grant; capture it then.
      if (r_rd_p1) begin
        r_rd_data <= i_ram_q;
      end
    end
  end

  assign o_clr_busy = w_clr_busy;
  assign o_wr_gnt   = w_wr_gnt;
  assign o_rd_gnt   = w_rd_gnt;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_ram_addr = w_ram_addr;
  assign o_ram_data = w_ram_data;
  assign o_ram_we   = w_ram_we;

endmodule

`default_nettype wire
